// File: rtl/perf_counter_snapshot.sv
// perf_counter_snapshot: per-channel rising-edge event counters with periodic or
// manual snapshots, streamed out as a byte frame: A5, counter bytes, checksum.
module perf_counter_snapshot #(
  parameter int unsigned NCH    = 8,
  parameter int unsigned CW     = 16,
  parameter int unsigned PERIOD = 60000,
  parameter int unsigned SAT    = 1,
  parameter int unsigned CLR    = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic [NCH-1:0] ev_i,
  input  logic           snap_i,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           busy_o,
  output logic           overrun_o
);

  localparam int unsigned NB     = CW / 8;
  localparam int unsigned NBYTES = NCH * NB;
  localparam int unsigned TW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int unsigned IDXW   = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM
  } state_t;

  state_t            state_q, state_d;
  logic [NCH-1:0]    ev_prev_q;
  logic [CW-1:0]     cnt_q  [NCH];
  logic [CW-1:0]     cnt_d  [NCH];
  logic [CW-1:0]     snap_q [NCH];
  logic [CW-1:0]     snap_d [NCH];
  logic [TW-1:0]     timer_q, timer_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic              overrun_q, overrun_d;

  logic [NCH-1:0]    inc;
  logic              timer_hit;
  logic              trig;
  logic              accept;
  logic [7:0]        data_byte;

  // Edge detection, trigger sources and snapshot acceptance
  always_comb begin
    inc       = en_i ? (ev_i & ~ev_prev_q) : '0;
    timer_hit = (timer_q == TW'(PERIOD - 1));
    trig      = timer_hit | snap_i;
    accept    = trig & (state_q == S_IDLE);
    timer_d   = timer_hit ? '0 : timer_q + TW'(1);
    overrun_d = overrun_q | (trig & (state_q != S_IDLE));
  end

  // Counter update and snapshot capture; the snapshot takes pre-increment values
  // while a restarting counter keeps this cycle's edge so nothing is lost.
  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      snap_d[k] = accept ? cnt_q[k] : snap_q[k];
      cnt_d[k]  = cnt_q[k];
      if (accept && (CLR != 0)) begin
        cnt_d[k] = CW'(inc[k]);
      end else if (inc[k]) begin
        if ((SAT != 0) && (cnt_q[k] == '1)) begin
          cnt_d[k] = cnt_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
  end

  // Select the current DATA byte: channel 0 first, MSB byte first within a channel
  always_comb begin
    data_byte = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      for (int unsigned j = 0; j < NB; j++) begin
        if (idx_q == IDXW'(ch * NB + j)) begin
          data_byte = snap_q[ch][(CW - 1 - 8 * j) -: 8];
        end
      end
    end
  end

  // Frame FSM next-state and output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    tx_valid = 1'b0;
    tx_data  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_HDR;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        if (tx_ready) state_d = S_DATA;
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_byte;
        if (tx_ready) begin
          csum_d = csum_q + data_byte;
          if (idx_q == IDXW'(NBYTES - 1)) begin
            state_d = S_CSUM;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign overrun_o = overrun_q;

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ev_prev_q <= '0;
      timer_q   <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      overrun_q <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        cnt_q[k]  <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ev_prev_q <= ev_i;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      overrun_q <= overrun_d;
      for (int unsigned k = 0; k < NCH; k++) begin
        cnt_q[k]  <= cnt_d[k];
        snap_q[k] <= snap_d[k];
      end
    end
  end

endmodule
